// File: rtl/matrix_stream_packer_pkg.sv
// Shared types, defaults and the slot-ordering function for the matrix stream packer.
package pca_pkg;

   localparam int unsigned ELEM_WIDTH = 8;
   localparam int unsigned DEF_ROWS   = 4;
   localparam int unsigned DEF_COLS   = 4;

   typedef logic [ELEM_WIDTH-1:0] elem_t;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_e;

   // Flat slot index of element (r,c): row-major k = r*cols+c, transposed k = c*rows+r.
   function automatic int unsigned slot_idx(input int unsigned r,
                                            input int unsigned c,
                                            input logic        transpose,
                                            input int unsigned rows,
                                            input int unsigned cols);
      return transpose ? (c * rows + r) : (r * cols + c);
   endfunction

endpackage

// File: rtl/matrix_stream_packer_if.sv
// Row-in / frame-out handshake bundle of the matrix stream packer.
interface matrix_stream_packer_if
   import pca_pkg::*;
#(
   parameter int unsigned ROWS       = DEF_ROWS,
   parameter int unsigned COLS       = DEF_COLS,
   parameter int unsigned DATA_WIDTH = ELEM_WIDTH
);

   logic                            flush;
   logic                            transpose;
   logic                            in_valid;
   logic                            in_ready;
   logic [DATA_WIDTH-1:0]           in_row [COLS];
   logic                            in_last;
   logic                            out_valid;
   logic                            out_ready;
   logic [ROWS*COLS*DATA_WIDTH-1:0] out_frame;
   logic                            out_transposed;
   logic                            frame_err;

   // Producer / consumer side (drives rows, accepts frames).
   modport master (
      output flush, transpose, in_valid, in_row, in_last, out_ready,
      input  in_ready, out_valid, out_frame, out_transposed, frame_err
   );

   // Packer side.
   modport slave (
      input  flush, transpose, in_valid, in_row, in_last, out_ready,
      output in_ready, out_valid, out_frame, out_transposed, frame_err
   );

endinterface

// File: rtl/matrix_stream_packer_frame_slot_writer.sv
// Combinational decode of one incoming row into per-slot write enables and data.
module frame_slot_writer
   import pca_pkg::*;
#(
   parameter int unsigned ROWS       = DEF_ROWS,
   parameter int unsigned COLS       = DEF_COLS,
   parameter int unsigned DATA_WIDTH = ELEM_WIDTH,
   parameter int unsigned CNT_W      = 2
) (
   input  logic                            wr_en_i,
   input  logic [CNT_W-1:0]                row_i,
   input  logic                            transpose_i,
   input  logic [DATA_WIDTH-1:0]           row_data_i [COLS],
   output logic [ROWS*COLS-1:0]            slot_we_o,
   output logic [ROWS*COLS*DATA_WIDTH-1:0] slot_data_o
);

   for (genvar k = 0; k < ROWS*COLS; k++) begin : g_slot
      localparam int unsigned K = k;
      logic                  we;
      logic [DATA_WIDTH-1:0] data;

      // Find which column of the current row (if any) lands in slot K.
      always_comb begin
         // NOTE: defaults first so every path assigns we/data and no latch is inferred.
         we   = 1'b0;
         data = '0;
         for (int unsigned c = 0; c < COLS; c++) begin
            if (slot_idx(32'(row_i), c, transpose_i, ROWS, COLS) == K) begin
               we   = wr_en_i;
               data = row_data_i[c];
            end
         end
      end

      assign slot_we_o[k]                                = we;
      assign slot_data_o[k*DATA_WIDTH +: DATA_WIDTH]     = data;
   end

endmodule

// File: rtl/matrix_stream_packer.sv
// Assembles ROWS streamed rows into one packed frame (row-major or transposed)
// and presents it on a valid/ready output.
module matrix_stream_packer
   import pca_pkg::*;
#(
   parameter int unsigned ROWS       = DEF_ROWS,
   parameter int unsigned COLS       = DEF_COLS,
   parameter int unsigned DATA_WIDTH = ELEM_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   matrix_stream_packer_if.slave  bus
);

   localparam int unsigned       CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned       FRAME_W  = ROWS * COLS * DATA_WIDTH;
   localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(ROWS - 1);

   pack_state_e          state_q;
   logic [CNT_W-1:0]     row_cnt_q;
   logic                 mode_q;
   logic                 out_valid_q;
   logic                 frame_err_q;
   logic [FRAME_W-1:0]   frame_q;
   logic [FRAME_W-1:0]   frame_d;

   logic                 in_ready_w;
   logic                 accept;
   logic                 last_row;
   logic                 beat_mode;
   logic [ROWS*COLS-1:0] slot_we;
   logic [FRAME_W-1:0]   slot_data;

   // Flush blocks acceptance so a beat in the flush cycle is dropped.
   assign in_ready_w = (state_q == FILL) && !bus.flush;
   assign accept     = bus.in_valid && in_ready_w;
   assign last_row   = (row_cnt_q == LAST_ROW);
   // Mode is taken from the input only on the first row, then held for the frame.
   assign beat_mode  = (row_cnt_q == '0) ? bus.transpose : mode_q;

   frame_slot_writer #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
   ) u_writer (
      .wr_en_i     (accept),
      .row_i       (row_cnt_q),
      .transpose_i (beat_mode),
      .row_data_i  (bus.in_row),
      .slot_we_o   (slot_we),
      .slot_data_o (slot_data)
   );

   // Unwritten slots keep their previous contents.
   for (genvar k = 0; k < ROWS*COLS; k++) begin : g_merge
      assign frame_d[k*DATA_WIDTH +: DATA_WIDTH] =
         slot_we[k] ? slot_data[k*DATA_WIDTH +: DATA_WIDTH]
                    : frame_q[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // Frame storage: updated on every accepted row.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the frame buffer is reset because out_frame must read zero after reset.
      if (!rst_n) begin
         frame_q <= '0;
      end else if (accept) begin
         frame_q <= frame_d;
      end
   end

   // Fill/hold FSM with row counter, mode latch and sticky framing error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         row_cnt_q   <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates based on pre-edge values.
         case (state_q)
            FILL: begin
               if (bus.flush) begin
                  row_cnt_q <= '0;
               end else if (accept) begin
                  mode_q <= beat_mode;
                  if (bus.in_last != last_row) begin
                     frame_err_q <= 1'b1;
                  end
                  if (last_row) begin
                     row_cnt_q   <= '0;
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                  end else begin
                     row_cnt_q <= row_cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_valid_q && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= FILL;
               end
            end
            default: begin
               state_q <= FILL;
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready_w;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_frame      = frame_q;
   assign bus.out_transposed = mode_q;
   assign bus.frame_err      = frame_err_q;

endmodule

// File: tb/tb_matrix_stream_packer.sv
// Directed bench for matrix_stream_packer (ROWS=COLS=4, 8-bit elements).
module tb_matrix_stream_packer;
   import pca_pkg::*;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned FW   = ROWS * COLS * DW;

   // Row r, column c carries base + r*16 + c.
   localparam logic [FW-1:0] RM_FRAME = 128'h33323130_23222120_13121110_03020100;
   localparam logic [FW-1:0] TR_FRAME = 128'h33231303_32221202_31211101_30201000;
   localparam logic [FW-1:0] HI_FRAME = 128'hb3b2b1b0_a3a2a1a0_93929190_83828180;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   matrix_stream_packer_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) bus ();

   matrix_stream_packer #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .DATA_WIDTH (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one row at a negedge and advance to the next negedge.
   task automatic drive_beat(input int unsigned r, input elem_t base, input logic tr, input logic last);
      for (int unsigned c = 0; c < COLS; c++) begin
         bus.in_row[c] = base + elem_t'(r * 16 + c);
      end
      bus.in_valid  = 1'b1;
      bus.transpose = tr;
      bus.in_last   = last;
      @(negedge clk);
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.transpose = 1'b0;
   endtask

   // Four-row frame: tr0 on the first beat, tr_rest on the others.
   task automatic send_frame(input elem_t base, input logic tr0, input logic tr_rest);
      for (int unsigned r = 0; r < ROWS; r++) begin
         drive_beat(r, base, (r == 0) ? tr0 : tr_rest, r == ROWS - 1);
      end
      idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      for (int unsigned c = 0; c < COLS; c++) bus.in_row[c] = '0;
      idle();

      // Reset state
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_frame", bus.out_frame, 0);
      check("rst_out_transposed", bus.out_transposed, 0);
      check("rst_frame_err", bus.frame_err, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);

      // Row-major frame, downstream always ready
      drive_beat(0, 8'h00, 1'b0, 1'b0);
      drive_beat(1, 8'h00, 1'b0, 1'b0);
      drive_beat(2, 8'h00, 1'b0, 1'b0);
      check("rm_no_early_valid", bus.out_valid, 0);
      drive_beat(3, 8'h00, 1'b0, 1'b1);
      idle();
      check("rm_out_valid", bus.out_valid, 1);
      check("rm_out_frame", bus.out_frame, RM_FRAME);
      check("rm_out_transposed", bus.out_transposed, 0);
      check("rm_in_ready_hold", bus.in_ready, 0);
      check("rm_frame_err", bus.frame_err, 0);
      @(negedge clk);
      check("rm_valid_dropped", bus.out_valid, 0);
      check("rm_in_ready_back", bus.in_ready, 1);

      // Transposed frame, transpose toggled mid-frame, then backpressure
      bus.out_ready = 1'b0;
      send_frame(8'h00, 1'b1, 1'b0);
      check("tr_out_valid", bus.out_valid, 1);
      check("tr_out_frame", bus.out_frame, TR_FRAME);
      check("tr_out_transposed", bus.out_transposed, 1);
      for (int i = 0; i < 10; i++) begin
         drive_beat(0, 8'hee, 1'b0, 1'b0);
         check("bp_out_frame_stable", bus.out_frame, TR_FRAME);
         check("bp_in_ready_low", bus.in_ready, 0);
         check("bp_out_valid_high", bus.out_valid, 1);
         check("bp_transposed_stable", bus.out_transposed, 1);
      end
      idle();
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready_same_cycle", bus.in_ready, 0);
      @(negedge clk);
      check("release_out_valid", bus.out_valid, 0);
      check("release_in_ready_next", bus.in_ready, 1);

      // Next frame after backpressure, new data
      send_frame(8'h80, 1'b0, 1'b0);
      check("hi_out_valid", bus.out_valid, 1);
      check("hi_out_frame", bus.out_frame, HI_FRAME);
      check("hi_out_transposed", bus.out_transposed, 0);
      @(negedge clk);

      // Flush after two beats, with a beat offered in the flush cycle
      drive_beat(0, 8'h55, 1'b1, 1'b0);
      drive_beat(1, 8'h55, 1'b1, 1'b0);
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.transpose = 1'b1;
      #1;
      check("flush_in_ready", bus.in_ready, 0);
      @(negedge clk);
      bus.flush = 1'b0;
      idle();
      check("flush_no_output", bus.out_valid, 0);
      send_frame(8'h00, 1'b0, 1'b0);
      check("flush_clean_valid", bus.out_valid, 1);
      check("flush_clean_frame", bus.out_frame, RM_FRAME);
      check("flush_clean_transposed", bus.out_transposed, 0);
      check("flush_frame_err", bus.frame_err, 0);
      @(negedge clk);

      // Early in_last on the third beat
      drive_beat(0, 8'h00, 1'b0, 1'b0);
      drive_beat(1, 8'h00, 1'b0, 1'b0);
      drive_beat(2, 8'h00, 1'b0, 1'b1);
      check("early_last_err", bus.frame_err, 1);
      check("early_last_no_valid", bus.out_valid, 0);
      drive_beat(3, 8'h00, 1'b0, 1'b1);
      idle();
      check("early_last_valid", bus.out_valid, 1);
      check("early_last_frame", bus.out_frame, RM_FRAME);
      @(negedge clk);
      check("early_last_err_sticky", bus.frame_err, 1);

      // Asynchronous reset while holding a frame
      bus.out_ready = 1'b0;
      send_frame(8'h80, 1'b1, 1'b1);
      check("pre_rst_valid", bus.out_valid, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", bus.out_valid, 0);
      check("async_rst_out_frame", bus.out_frame, 0);
      check("async_rst_frame_err", bus.frame_err, 0);
      check("async_rst_transposed", bus.out_transposed, 0);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("post_async_in_ready", bus.in_ready, 1);
      check("post_async_out_valid", bus.out_valid, 0);

      // Recovery frame after reset
      send_frame(8'h00, 1'b1, 1'b1);
      check("recover_valid", bus.out_valid, 1);
      check("recover_frame", bus.out_frame, TR_FRAME);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
